// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_stall_ctrl_pkg;

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_SAT = 16'hFFFF;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DRAIN  = 2'b01,
    HALTED = 2'b10
  } state_e;

endpackage : pipe_stall_ctrl_pkg

// File: rtl/pipe_stall_ctrl_if.sv
// Event inputs and per-stage controls between hazard logic and the stall controller.
interface pipe_stall_ctrl_if;
  import pipe_stall_ctrl_pkg::*;

  logic             stallFD;
  logic             branch_takenD;
  logic             haltD;
  logic             haltW;
  logic             icache_miss;
  logic             dcache_miss;
  logic             pc_we;
  logic             fd_we;
  logic             fd_flush;
  logic             dx_we;
  logic             dx_flush;
  logic             xm_we;
  logic             mw_we;
  logic             halted;
  logic [CNT_W-1:0] stall_cycles;

  // Event source side (hazard unit, caches, decode/WB).
  modport master (
    output stallFD, branch_takenD, haltD, haltW, icache_miss, dcache_miss,
    input  pc_we, fd_we, fd_flush, dx_we, dx_flush, xm_we, mw_we, halted, stall_cycles
  );

  // Controller side.
  modport slave (
    input  stallFD, branch_takenD, haltD, haltW, icache_miss, dcache_miss,
    output pc_we, fd_we, fd_flush, dx_we, dx_flush, xm_we, mw_we, halted, stall_cycles
  );

endinterface : pipe_stall_ctrl_if

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter
  import pipe_stall_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear wins, otherwise increment until the ceiling.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != CNT_SAT)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule : sat_counter

// File: rtl/pipe_stall_ctrl.sv
// Converts stall/branch/miss/halt events into PC and pipeline register enables and flushes,
// runs the halt-drain sequence and counts fetch-stall cycles.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  pipe_stall_ctrl_if.slave  bus
);

  state_e state_q;
  state_e state_d;
  logic   halted_q;

  logic pc_we_c;
  logic fd_we_c;
  logic fd_flush_c;
  logic dx_we_c;
  logic dx_flush_c;
  logic xm_we_c;
  logic mw_we_c;
  logic cnt_inc_c;

  // State and halted flag registers; halted tracks entry into HALTED.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= (state_d == HALTED);
    end
  end

  // Next state and Mealy stage controls.
  always_comb begin
    state_d    = state_q;
    pc_we_c    = 1'b1;
    fd_we_c    = 1'b1;
    fd_flush_c = 1'b0;
    dx_we_c    = 1'b1;
    dx_flush_c = 1'b0;
    xm_we_c    = 1'b1;
    mw_we_c    = 1'b1;

    unique case (state_q)
      RUN: begin
        if (bus.dcache_miss) begin
          pc_we_c = 1'b0;
          fd_we_c = 1'b0;
          dx_we_c = 1'b0;
          xm_we_c = 1'b0;
          mw_we_c = 1'b0;
        end else if (bus.stallFD) begin
          pc_we_c    = 1'b0;
          fd_we_c    = 1'b0;
          dx_flush_c = 1'b1;
        end else if (bus.branch_takenD) begin
          fd_flush_c = 1'b1;
        end else if (bus.icache_miss) begin
          pc_we_c    = 1'b0;
          fd_flush_c = 1'b1;
        end
        if (bus.haltD && !bus.dcache_miss && !bus.stallFD) begin
          state_d = DRAIN;
        end
      end

      DRAIN: begin
        if (bus.dcache_miss) begin
          pc_we_c = 1'b0;
          fd_we_c = 1'b0;
          dx_we_c = 1'b0;
          xm_we_c = 1'b0;
          mw_we_c = 1'b0;
        end else begin
          pc_we_c    = 1'b0;
          fd_flush_c = 1'b1;
        end
        if (bus.haltW && !bus.dcache_miss) begin
          state_d = HALTED;
        end
      end

      HALTED: begin
        pc_we_c = 1'b0;
        fd_we_c = 1'b0;
        dx_we_c = 1'b0;
        xm_we_c = 1'b0;
        mw_we_c = 1'b0;
      end

      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Any RUN cycle that holds the PC counts as a stall cycle.
  assign cnt_inc_c = (state_q == RUN) && !pc_we_c;

  sat_counter u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (cnt_inc_c),
    .clr_i   (1'b0),
    .count_o (bus.stall_cycles)
  );

  assign bus.pc_we    = pc_we_c;
  assign bus.fd_we    = fd_we_c;
  assign bus.fd_flush = fd_flush_c;
  assign bus.dx_we    = dx_we_c;
  assign bus.dx_flush = dx_flush_c;
  assign bus.xm_we    = xm_we_c;
  assign bus.mw_we    = mw_we_c;
  assign bus.halted   = halted_q;

endmodule : pipe_stall_ctrl

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: behavioural model plus directed and random stimulus.
module tb_pipe_stall_ctrl;

  logic clk;
  logic rst;

  pipe_stall_ctrl_if bus ();

  pipe_stall_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  // Model: 0 = running, 1 = draining, 2 = halted.
  int m_mode;
  int m_cnt;
  bit m_valid;

  // Control vector {pc_we, fd_we, fd_flush, dx_we, dx_flush, xm_we, mw_we}.
  function automatic logic [6:0] model_ctrl(int mode, logic st, logic br, logic ic, logic dc);
    logic pc, fw, ff, dw, df, xw, mw;
    if (mode == 2 || dc) return 7'b0000000;
    if (mode == 1) return 7'b0111011;
    pc = !(st || (ic && !br));
    fw = !st;
    ff = !st && (br || ic);
    dw = 1'b1;
    df = st;
    xw = 1'b1;
    mw = 1'b1;
    return {pc, fw, ff, dw, df, xw, mw};
  endfunction

  function automatic logic [6:0] dut_ctrl();
    return {bus.pc_we, bus.fd_we, bus.fd_flush, bus.dx_we, bus.dx_flush, bus.xm_we, bus.mw_we};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // One clock: drive inputs after the edge, compare mid-cycle, then advance the model.
  task automatic step(input logic r, input logic st, input logic br, input logic hd,
                      input logic hw, input logic ic, input logic dc);
    logic [6:0] exp_ctrl;
    @(posedge clk);
    #1;
    rst               = r;
    bus.stallFD       = st;
    bus.branch_takenD = br;
    bus.haltD         = hd;
    bus.haltW         = hw;
    bus.icache_miss   = ic;
    bus.dcache_miss   = dc;
    @(negedge clk);
    exp_ctrl = model_ctrl(m_mode, st, br, ic, dc);
    if (m_valid) begin
      chk("ctrl", int'(dut_ctrl()), int'(exp_ctrl));
      chk("halted", int'(bus.halted), (m_mode == 2) ? 1 : 0);
      chk("stall_cycles", int'(bus.stall_cycles), m_cnt);
    end
    if (r) begin
      m_mode  = 0;
      m_cnt   = 0;
      m_valid = 1'b1;
    end else begin
      if (m_mode == 0 && !exp_ctrl[6] && m_cnt < 65535) m_cnt++;
      if (m_mode == 0 && hd && !dc && !st) m_mode = 1;
      else if (m_mode == 1 && hw && !dc) m_mode = 2;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    m_mode  = 0;
    m_cnt   = 0;
    m_valid = 1'b0;
    rst = 1'b1;
    bus.stallFD = 0; bus.branch_takenD = 0; bus.haltD = 0;
    bus.haltW = 0; bus.icache_miss = 0; bus.dcache_miss = 0;

    // Reset then idle.
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    idle(3);
    chk("lit_idle_ctrl", int'(dut_ctrl()), int'(7'b1101011));
    chk("lit_idle_halted", int'(bus.halted), 0);
    chk("lit_idle_cnt", int'(bus.stall_cycles), 0);

    // Two-cycle load-use stall.
    step(0, 1, 0, 0, 0, 0, 0);
    chk("lit_stall_ctrl", int'(dut_ctrl()), int'(7'b0001111));
    step(0, 1, 0, 0, 0, 0, 0);
    chk("lit_stall_ctrl2", int'(dut_ctrl()), int'(7'b0001111));
    idle(1);
    chk("lit_stall_cnt", int'(bus.stall_cycles), 2);

    // Stall masks branch, then branch alone redirects.
    step(0, 1, 1, 0, 0, 0, 0);
    chk("lit_stall_br_ctrl", int'(dut_ctrl()), int'(7'b0001111));
    step(0, 0, 1, 0, 0, 1, 0);
    chk("lit_branch_ctrl", int'(dut_ctrl()), int'(7'b1111011));

    // Data-cache miss freezes everything.
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 0, 0, 1, 1);
      chk("lit_dmiss_ctrl", int'(dut_ctrl()), 0);
    end
    idle(1);
    chk("lit_dmiss_cnt", int'(bus.stall_cycles), 6);

    // Halt drain: haltD, quiet, dcache miss, haltW.
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("lit_drain_ctrl", int'(dut_ctrl()), int'(7'b0111011));
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("lit_drain_last_halted", int'(bus.halted), 0);
    idle(1);
    chk("lit_halted", int'(bus.halted), 1);
    chk("lit_halted_ctrl", int'(dut_ctrl()), 0);
    chk("lit_halted_cnt", int'(bus.stall_cycles), 6);
    step(0, 1, 1, 1, 1, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    idle(1);
    chk("lit_rst_halted", int'(bus.halted), 0);
    chk("lit_rst_ctrl", int'(dut_ctrl()), int'(7'b1101011));

    // Randomised traffic with occasional reset.
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 63) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
    end

    // Saturation.
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 65540; i++) step(0, 1, 0, 0, 0, 0, 0);
    idle(1);
    chk("lit_sat_cnt", int'(bus.stall_cycles), 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_pipe_stall_ctrl
